// File: rtl/lx32_pkg.sv
// Shared definitions for the lx32 peripheral slice: register offsets,
// STATUS bit positions and the UART transmitter state encoding.
package lx32_pkg;

    localparam logic [31:0] REG_TXDATA = 32'h0000_0000;
    localparam logic [31:0] REG_STATUS = 32'h0000_0004;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_ACTIVE    = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/lx32_sync_fifo.sv
// Single-clock FIFO with power-of-two depth; pointers wrap naturally and a
// concurrent push/pop on a full FIFO is accepted.
module lx32_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lx32_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a small FIFO,
// STATUS reports FIFO/line state and a sticky overflow flag.
//
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | driving the start bit (0)
//   DATA  | shifting 8 data bits out LSB first
//   STOP  | driving the stop bit (1), then chain to next byte or idle
module lx32_uart_tx
    import lx32_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    output logic [31:0] mem_rdata,
    output logic        uart_tx,
    output logic        tx_busy
);

    localparam int CW = $clog2(FIFO_DEPTH);
    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] BIT_LAST    = TW'(CLKS_PER_BIT - 1);
    localparam logic [31:0]   TXDATA_ADDR = BASE_ADDR + REG_TXDATA;
    localparam logic [31:0]   STATUS_ADDR = BASE_ADDR + REG_STATUS;

    tx_state_e     state_q;
    tx_state_e     state_d;
    logic [TW-1:0] timer_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          bit_end;
    logic          tx_next;
    logic          tx_active;
    logic          ovf_q;

    logic          sel_txdata;
    logic          sel_status;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW:0]   fifo_count;
    logic [4:0]    count_ext;
    logic          ovf_set;
    logic          ovf_clr;
    logic [31:0]   status_word;
    logic          unused_bits;

    assign sel_txdata = (mem_addr[31:2] == TXDATA_ADDR[31:2]);
    assign sel_status = (mem_addr[31:2] == STATUS_ADDR[31:2]);

    // A push into a full FIFO is only accepted when the FSM frees a slot this cycle.
    assign fifo_push = mem_we && sel_txdata && (!fifo_full || fifo_pop);
    assign ovf_set   = mem_we && sel_txdata && fifo_full && !fifo_pop;
    assign ovf_clr   = mem_we && sel_status && mem_wdata[3];

    lx32_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (mem_wdata[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_end = (timer_q == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end && (idx_q == 3'd7)) state_d = STOP;
            STOP:    if (bit_end) state_d = fifo_empty ? IDLE : START;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_pop = 1'b0;
        tx_next  = 1'b1;
        case (state_q)
            IDLE:    fifo_pop = !fifo_empty;
            START:   tx_next  = 1'b0;
            DATA:    tx_next  = shift_q[0];
            STOP:    fifo_pop = bit_end && !fifo_empty;
            default: tx_next  = 1'b1;
        endcase
    end

    assign tx_active = (state_q != IDLE);
    assign tx_busy   = !fifo_empty || tx_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            uart_tx <= 1'b1;
        end else begin
            uart_tx <= tx_next;
            if (fifo_pop) begin
                shift_q <= fifo_rdata;
            end else if ((state_q == DATA) && bit_end) begin
                shift_q <= {1'b0, shift_q[7:1]};
            end
            if ((state_q == IDLE) || bit_end) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + 1'b1;
            end
            if (state_q != DATA) begin
                idx_q <= '0;
            end else if (bit_end) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    // Overflow wins over a same-cycle clear so no dropped byte goes unreported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign count_ext = 5'(fifo_count);

    always_comb begin
        status_word                          = '0;
        status_word[STAT_FULL]               = fifo_full;
        status_word[STAT_EMPTY]              = fifo_empty;
        status_word[STAT_ACTIVE]             = tx_active;
        status_word[STAT_OVF]                = ovf_q;
        status_word[STAT_COUNT_LSB +: 4]     = count_ext[3:0];
    end

    assign mem_rdata = sel_status ? status_word : 32'h0;

    assign unused_bits = &{1'b0, mem_addr[1:0], mem_wdata[31:8], count_ext[4]};

endmodule

// File: tb/tb_lx32_uart_tx.sv
// Bench for lx32_uart_tx: a queue/frame-position model predicts the pin,
// tx_busy and register reads every cycle; directed cases add literal checks.
module tb_lx32_uart_tx;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam int          FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_addr = BASE + 32'd4;
    logic [31:0] mem_wdata = 32'h0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_rdata;
    logic        uart_tx;
    logic        tx_busy;

    int n_vec = 0;
    int n_bad = 0;

    lx32_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .uart_tx   (uart_tx),
        .tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mq[$];
    logic       m_in_frame = 1'b0;
    logic [7:0] m_cur = 8'h0;
    int         m_pos = 0;
    logic       m_pin = 1'b1;
    logic       m_ovf = 1'b0;

    function automatic logic line_level(input logic [7:0] b, input int pos);
        int k;
        k = pos / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        logic [31:0] sa;
        logic [3:0]  cnt;
        sa = BASE + 32'd4;
        if (a[31:2] != sa[31:2]) return 32'h0;
        cnt = 4'(mq.size());
        return {24'h0, cnt, m_ovf, m_in_frame, mq.size() == 0, mq.size() == DEPTH};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic        pop_now, full_now, sel_tx, sel_st, push_ok, ovf_set;
        logic [31:0] ta, sa;
        if (!rst_n) begin
            mq.delete();
            m_in_frame = 1'b0;
            m_pos      = 0;
            m_pin      = 1'b1;
            m_ovf      = 1'b0;
        end else begin
            ta       = BASE;
            sa       = BASE + 32'd4;
            sel_tx   = (mem_addr[31:2] == ta[31:2]);
            sel_st   = (mem_addr[31:2] == sa[31:2]);
            pop_now  = (!m_in_frame || m_pos == FRAME - 1) && (mq.size() > 0);
            full_now = (mq.size() == DEPTH);
            push_ok  = mem_we && sel_tx && (!full_now || pop_now);
            ovf_set  = mem_we && sel_tx && full_now && !pop_now;
            m_pin    = m_in_frame ? line_level(m_cur, m_pos) : 1'b1;
            if (pop_now) begin
                m_cur      = mq.pop_front();
                m_in_frame = 1'b1;
                m_pos      = 0;
            end else if (m_in_frame) begin
                if (m_pos == FRAME - 1) m_in_frame = 1'b0;
                else m_pos++;
            end
            if (push_ok) mq.push_back(mem_wdata[7:0]);
            if (ovf_set) m_ovf = 1'b1;
            else if (mem_we && sel_st && mem_wdata[3]) m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("uart_tx", uart_tx, m_pin);
        chk("tx_busy", tx_busy, (mq.size() != 0) || m_in_frame);
        chk("mem_rdata", mem_rdata, exp_rdata(mem_addr));
    end

    // ---------------- stimulus helpers (entered/left just after posedge) ----------------
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_addr  = a;
        mem_wdata = d;
        mem_we    = 1'b1;
        @(posedge clk);
        #1;
        mem_we    = 1'b0;
        mem_addr  = BASE + 32'd4;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        mem_addr = a;
        @(negedge clk);
        v = mem_rdata;
        @(posedge clk);
        #1;
        mem_addr = BASE + 32'd4;
    endtask

    task automatic wait_start(input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (uart_tx == 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        chk(name, found, 1'b1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!tx_busy) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, done, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] v;
        logic [9:0]  bits;
        int          zeros;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // register window decode
        rd(BASE + 32'd8, v);      chk("rd_off8", v, 32'h0);
        rd(BASE, v);              chk("rd_txdata", v, 32'h0);
        rd(32'h2000_0004, v);     chk("rd_outside", v, 32'h0);
        rd(BASE + 32'd4, v);      chk("rd_status_idle", v, 32'h2);
        rd(BASE + 32'd7, v);      chk("rd_status_bytelane", v, 32'h2);

        // single frame 0xA5
        wr(BASE, 32'hA5);
        wait_start("a5_start_seen");
        for (int b = 0; b < 10; b++) begin
            bits[b] = uart_tx;
            if (b < 9) repeat (CPB) @(negedge clk);
        end
        chk("a5_frame", bits, 10'h34A);
        chk("a5_busy_in_stop", tx_busy, 1'b1);
        repeat (CPB) @(negedge clk);
        chk("a5_busy_after_stop", tx_busy, 1'b0);
        chk("a5_line_idle", uart_tx, 1'b1);
        @(posedge clk);
        #1;

        // back-to-back frames
        wr(BASE, 32'h11);
        wr(BASE, 32'h22);
        rd(BASE + 32'd4, v);      chk("b2b_count1", (v >> 4) & 32'hF, 32'd1);
        wait_start("b2b_start_seen");
        repeat (FRAME) @(negedge clk);
        chk("b2b_second_start", uart_tx, 1'b0);
        chk("b2b_count0", (mem_rdata >> 4) & 32'hF, 32'd0);
        wait_idle("b2b_idle", 200);

        // overflow with 6 consecutive writes
        for (int i = 0; i < 6; i++) wr(BASE, 32'h30 + i);
        rd(BASE + 32'd4, v);      chk("ovf_status", v, 32'h4D);
        wr(BASE + 32'd4, 32'h8);
        rd(BASE + 32'd4, v);      chk("ovf_cleared", v, 32'h45);
        wait_idle("ovf_drain", 400);
        rd(BASE + 32'd4, v);      chk("ovf_idle_status", v, 32'h2);

        // push while full, coinciding with the stop->start pop
        for (int i = 0; i < 5; i++) wr(BASE, 32'h61 + i);
        repeat (36) @(posedge clk);
        #1;
        wr(BASE, 32'h66);
        rd(BASE + 32'd4, v);      chk("full_push_pop", v, 32'h45);
        wait_idle("full_drain", 600);

        // reset mid-DATA of 0xFF
        wr(BASE, 32'hFF);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_uart_tx", uart_tx, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_status", mem_rdata, 32'h2);
        @(posedge clk);
        #2 rst_n = 1'b1;
        zeros = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (uart_tx == 1'b0) zeros++;
        end
        chk("rst_no_frame", zeros, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
